// File: rtl/sn74ls595.sv
`default_nettype none
// ============================================================================
// Module   : sn74ls595
// Summary  : 8-bit serial-in/parallel-out shift register with storage latch.
//            SRCLK and RCLK are clock enables on clk; cascade through qh_s.
// Revision : 1.0 - initial release
// ============================================================================
module sn74ls595 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             ser,
  input  logic             sh_en,
  input  logic             st_en,
  input  logic             srclrn,
  input  logic             oen,
  output logic [WIDTH-1:0] q,
  output logic             q_oe,
  output logic             qh_s
);

  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_st;
  logic [WIDTH-1:0] w_sr_next;
  logic [WIDTH-1:0] w_st_next;

  // Synchronous clear beats shift; storage always samples the pre-edge shift
  // register so tied strobes make storage lag by one shift, as on the chip.
  always_comb begin
    w_sr_next = r_sr;
    w_st_next = r_st;
    if (!srclrn) begin
      w_sr_next = '0;
    end else if (sh_en) begin
      w_sr_next = {r_sr[WIDTH-2:0], ser};
    end
    if (st_en) begin
      w_st_next = r_sr;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_sr <= '0;
      r_st <= '0;
    end else begin
      r_sr <= w_sr_next;
      r_st <= w_st_next;
    end
  end

  assign q    = r_st;
  assign q_oe = ~oen;
  assign qh_s = r_sr[WIDTH-1];

endmodule
`default_nettype wire

// File: tb/tb_sn74ls595.sv
`default_nettype none
// ============================================================================
// Module   : tb_sn74ls595
// Summary  : Self-checking bench; two cascaded devices against a queue of
//            expected results built from a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sn74ls595;

  logic       clk;
  logic       clrn;
  logic       ser;
  logic       sh_en;
  logic       st_en;
  logic       srclrn;
  logic       oen;
  logic [7:0] q0, q1;
  logic       q_oe0, q_oe1;
  logic       qh0, qh1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] q0;
    logic [7:0] q1;
    logic       qh0;
    logic       qh1;
    logic       oe;
  } exp_t;

  exp_t sb[$];

  // Behavioural model of both devices
  logic [7:0] m_sr0, m_st0, m_sr1, m_st1;

  sn74ls595 #(.WIDTH(8)) u_lo (
    .clk(clk), .clrn(clrn), .ser(ser), .sh_en(sh_en), .st_en(st_en),
    .srclrn(srclrn), .oen(oen), .q(q0), .q_oe(q_oe0), .qh_s(qh0)
  );

  sn74ls595 #(.WIDTH(8)) u_hi (
    .clk(clk), .clrn(clrn), .ser(qh0), .sh_en(sh_en), .st_en(st_en),
    .srclrn(srclrn), .oen(oen), .q(q1), .q_oe(q_oe1), .qh_s(qh1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance the model by one edge using current inputs, push the expectation,
  // then let the DUT take the edge and compare.
  task automatic tick(input string tag);
    exp_t       e;
    logic [7:0] n_sr0, n_sr1;
    n_sr0 = m_sr0;
    n_sr1 = m_sr1;
    if (!srclrn) begin
      n_sr0 = 8'h00;
      n_sr1 = 8'h00;
    end else if (sh_en) begin
      n_sr0 = {m_sr0[6:0], ser};
      n_sr1 = {m_sr1[6:0], m_sr0[7]};
    end
    if (st_en) begin
      m_st0 = m_sr0;
      m_st1 = m_sr1;
    end
    m_sr0 = n_sr0;
    m_sr1 = n_sr1;
    if (!clrn) begin
      m_sr0 = 8'h00; m_sr1 = 8'h00; m_st0 = 8'h00; m_st1 = 8'h00;
    end
    e.q0 = m_st0; e.q1 = m_st1; e.qh0 = m_sr0[7]; e.qh1 = m_sr1[7]; e.oe = ~oen;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".q_lo"},  q0, e.q0);
    chk({tag, ".q_hi"},  q1, e.q1);
    chk({tag, ".qh_lo"}, {7'd0, qh0}, {7'd0, e.qh0});
    chk({tag, ".qh_hi"}, {7'd0, qh1}, {7'd0, e.qh1});
    chk({tag, ".q_oe"},  {7'd0, q_oe0}, {7'd0, e.oe});
  endtask

  task automatic shift_byte(input string tag, input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      ser = b[i]; sh_en = 1'b1; st_en = 1'b0; srclrn = 1'b1;
      tick(tag);
    end
    sh_en = 1'b0;
  endtask

  task automatic store(input string tag);
    sh_en = 1'b0; st_en = 1'b1; srclrn = 1'b1;
    tick(tag);
    st_en = 1'b0;
  endtask

  task automatic clear_sr(input string tag);
    sh_en = 1'b0; st_en = 1'b0; srclrn = 1'b0;
    tick(tag);
    srclrn = 1'b1;
  endtask

  initial begin
    m_sr0 = 8'h00; m_st0 = 8'h00; m_sr1 = 8'h00; m_st1 = 8'h00;
    clrn = 1'b0; ser = 1'b1; sh_en = 1'b1; st_en = 1'b1; srclrn = 1'b1; oen = 1'b0;

    // Reset held with every strobe active
    #1;
    chk("rst0.q", q0, 8'h00);
    chk("rst0.qh", {7'd0, qh0}, 8'h00);
    chk("rst0.q_oe", {7'd0, q_oe0}, 8'h01);
    tick("rst1");
    oen = 1'b1;
    tick("rst2");
    chk("rst2.q_oe_const", {7'd0, q_oe1}, 8'h00);
    oen = 1'b0;
    clrn = 1'b1; sh_en = 1'b0; st_en = 1'b0;

    // Load 0xB2; q must hold its previous value until the store
    shift_byte("load", 8'hB2);
    chk("load.pre_store", q0, 8'h00);
    store("load_st");
    chk("load.q", q0, 8'hB2);

    // Tied strobes: eight ones then a zero
    clear_sr("tied_clr");
    for (int i = 0; i < 9; i++) begin
      ser = (i < 8); sh_en = 1'b1; st_en = 1'b1;
      tick("tied");
      if (i == 7) chk("tied.q8", q0, 8'h7F);
    end
    chk("tied.q9", q0, 8'hFF);
    chk("tied.qh", {7'd0, qh0}, 8'h01);
    store("tied_sr");
    chk("tied.sr", q0, 8'hFE);

    // Clear priority over shift, storage keeps pre-clear value
    clear_sr("cp_clr");
    shift_byte("cp_load", 8'hA5);
    ser = 1'b1; sh_en = 1'b1; st_en = 1'b1; srclrn = 1'b0;
    tick("cp");
    chk("cp.q", q0, 8'hA5);
    chk("cp.qh", {7'd0, qh0}, 8'h00);
    srclrn = 1'b1; sh_en = 1'b0; st_en = 1'b0;
    tick("cp_next");
    store("cp_st");
    chk("cp.sr", q0, 8'h00);

    // Cascade 0x1234 through both devices, with the outputs disabled
    oen = 1'b1;
    shift_byte("casc_hi", 8'h12);
    shift_byte("casc_lo", 8'h34);
    chk("casc.qh_hi", {7'd0, qh1}, 8'h00);
    store("casc_st");
    chk("casc.q_hi", q1, 8'h12);
    chk("casc.q_lo", q0, 8'h34);
    oen = 1'b0;

    // Async reset mid-word
    shift_byte("ar_fill", 8'hFF);
    store("ar_st");
    for (int i = 0; i < 5; i++) begin
      ser = 1'b0; sh_en = 1'b1;
      tick("ar_sh");
    end
    sh_en = 1'b0;
    chk("ar.pre_qh", {7'd0, qh0}, 8'h01);
    chk("ar.pre_q", q0, 8'hFF);
    #2 clrn = 1'b0;
    #1;
    chk("ar.q", q0, 8'h00);
    chk("ar.qh", {7'd0, qh0}, 8'h00);
    chk("ar.q_hi", q1, 8'h00);
    m_sr0 = 8'h00; m_st0 = 8'h00; m_sr1 = 8'h00; m_st1 = 8'h00;
    #1 clrn = 1'b1;
    shift_byte("ar_new", 8'h5C);
    store("ar_new_st");
    chk("ar.new", q0, 8'h5C);
    chk("ar.new_hi", q1, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
